data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
MEM-stage access sequencer that sits directly upstream of the 256x8 big-endian data RAM.
- Accepts one load/store request from the pipeline and checks alignment and range.
- Drives the RAM's Enable/RW/Address/DataIn/Size pins for exactly one clean cycle per word.
- Registers the read data and sign- or zero-extends it before returning it.
- Sequences double-word transfers (LDRD/STRD) as two word accesses and stalls the pipeline while busy.

Parameters:
MEM_BYTES, 256, addressable bytes; any access touching a byte >= MEM_BYTES faults.

Ports:
Clk  in  1  clock, rising edge.
Reset_n  in  1  asynchronous active-low reset.
Req  in  1  request strobe; sampled only when Busy=0.
Load  in  1  1=load, 0=store.
Size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
Signed  in  1  sign-extend byte/halfword loads.
Addr  in  32  byte address.
StoreData  in  32  store data (low bits for byte/half; first word for double).
StoreData2  in  32  second store word (double only).
Busy  out  1  pipeline stall.
Done  out  1  one-cycle completion pulse.
Fault  out  1  valid with Done; misaligned or out-of-range request.
LoadData  out  32  extended load result / first double word.
LoadData2  out  32  second double word.
RamEnable  out  1  to RAM Enable.
RamRW  out  1  to RAM RW (1=write).
RamAddress  out  32  to RAM Address.
RamDataIn  out  32  to RAM DataIn.
RamSize  out  2  to RAM Size (00/01/10 only).
RamDataOut  in  32  from RAM; combinational read data.

Behaviour:
- Reset (async, Reset_n=0):
  - State goes to IDLE.
  - Busy, Done, Fault, LoadData, LoadData2, RamEnable, RamRW, RamAddress, RamDataIn and RamSize all go to 0 immediately.
  - Reset mid-access aborts the access. No partial second word is written.
- States:
  - IDLE: Busy=0, all Ram* outputs 0.
  - Req=1 at an edge latches Load, Size, Signed, Addr, StoreData, StoreData2 and evaluates Fault.
  - Fault conditions:
    - half with Addr[0]!=0;
    - word/double with Addr[1:0]!=0;
    - Addr+N-1 >= MEM_BYTES, where N=1/2/4/8. Computed in 33 bits so that 0xFFFFFFFF faults and does not wrap.
  - Faulting request goes to DONE with Fault=1. RamEnable stays 0 throughout.
  - Otherwise go to ACC1.
- ACC1:
  - Busy=1, RamEnable=1, RamRW=~Load, RamAddress=Addr.
  - RamSize = Size, except double uses 10.
  - RamDataIn = StoreData.
- RAM write timing:
  - All Ram* outputs are driven directly from flops; no combinational paths from inputs. This is mandatory because the RAM writes level-sensitively on any input change while RW=1.
  - RamRW is high only during ACC1/ACC2.
- Load capture: on a load, RamDataOut is captured at the end of ACC1 into LoadData, through the extender.
- Extension rules:
  - byte: Signed ? {24{d[7]}},d[7:0] : {24'b0,d[7:0]}.
  - half: same rule on d[15:0].
  - word/double: d[31:0] unmodified.
- Exit from ACC1: double goes to ACC2; otherwise DONE.
- ACC2:
  - RamAddress=Addr+4, RamDataIn=StoreData2, RamSize=10.
  - Load captures into LoadData2. Then DONE.
- DONE:
  - Done=1 for exactly one cycle; Busy=1; Ram* outputs 0. Then IDLE.
  - Req during DONE is ignored; the pipeline must hold and re-present it.
- Latency, Req accepted at edge t: single access gives Done in cycle t+2; double gives Done in t+3; fault gives Done in t+1.
- Output persistence:
  - LoadData/LoadData2 hold their value until the next completed load overwrites them.
  - Stores and faults leave them unchanged.
- Req while Busy=1 is ignored, with no side effects.
- Double address: Addr+4 is never computed beyond MEM_BYTES, because the range check guarantees this.

Decomposition:
- Package mem_pkg:
  - size codes SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10, SZ_DOUBLE=11;
  - state enum IDLE/ACC1/ACC2/DONE;
  - byte-count function size_bytes(Size).
- One sub-module: load_extend (Size, Signed, 32-bit raw in -> 32-bit extended out), purely combinational, reused by the writeback stage.

Test Plan:
1. Store word 0xDEADBEEF @0x10, then load word @0x10 -> RAM bytes 0x10..0x13 = DE AD BE EF; LoadData=0xDEADBEEF; Done at t+2 for each; Fault=0.
2. Store byte 0x80 @0x21, then load byte @0x21: Signed=1 -> 0xFFFFFF80; Signed=0 -> 0x00000080. Store half 0x8001 @0x22, load signed half -> 0xFFFF8001.
3. Double store 0x11111111/0x22222222 @0x40, then double load -> LoadData=0x11111111, LoadData2=0x22222222; Done at t+3; RamAddress sequence 0x40, 0x44.
4. Half @0x03 and word @0x02 -> Done at t+1 with Fault=1, RamEnable never 1, memory unchanged. Word @0xFC -> ok; double @0xFC -> Fault (0xFC+7 >= 256).
5. Req held high continuously -> accepted only in IDLE; exactly one Done per accepted request, accepts spaced 3 cycles apart; Busy and Done checked each cycle.
6. Reset_n low during ACC1 of a double store -> all outputs 0 asynchronously, bytes at Addr+4..+7 unchanged; first request after reset completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared size codes, controller states and byte-count helper for the MEM-stage data path.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE   = 2'b00;
   localparam logic [1:0] SZ_HALF   = 2'b01;
   localparam logic [1:0] SZ_WORD   = 2'b10;
   localparam logic [1:0] SZ_DOUBLE = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC1 = 2'b01,
      ACC2 = 2'b10,
      DONE = 2'b11
   } state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 4'd1;
         SZ_HALF: return 4'd2;
         SZ_WORD: return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw RAM read data; shared with the writeback stage.
module load_extend
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_raw,
   output logic [31:0] o_data
);

   always_comb begin
      o_data = i_raw;
      case (i_size)
         SZ_BYTE: o_data = {{24{i_signed & i_raw[7]}}, i_raw[7:0]};
         SZ_HALF: o_data = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
         default: o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage sequencer in front of the 256x8 big-endian data RAM: checks requests,
// drives registered RAM pins one clean cycle per word and returns extended load data.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_load,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_store_data2,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fault,
   output logic [31:0] o_load_data,
   output logic [31:0] o_load_data2,
   output logic        o_ram_enable,
   output logic        o_ram_rw,
   output logic [31:0] o_ram_address,
   output logic [31:0] o_ram_data_in,
   output logic [1:0]  o_ram_size,
   input  logic [31:0] i_ram_data_out
);

   state_e      r_state, w_state_d;

   logic        r_load, r_signed;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_store_data2;

   logic        r_busy, r_done, r_fault, r_ram_en, r_ram_rw;
   logic [31:0] r_ram_addr, r_ram_din, r_load_data, r_load_data2;
   logic [1:0]  r_ram_size;

   logic        w_busy_d, w_done_d, w_fault_d, w_ram_en_d, w_ram_rw_d;
   logic [31:0] w_ram_addr_d, w_ram_din_d, w_load_data_d, w_load_data2_d;
   logic [1:0]  w_ram_size_d;

   logic [32:0] w_last;
   logic        w_misalign, w_fault, w_accept;
   logic [31:0] w_ext;

   // 33-bit end address so requests near 0xFFFFFFFF fault instead of wrapping
   assign w_last   = {1'b0, i_addr} + {29'b0, size_bytes(i_size)} - 33'd1;
   assign w_fault  = w_misalign || (w_last >= 33'(MEM_BYTES));
   assign w_accept = (r_state == IDLE) && i_req;

   always_comb begin
      case (i_size)
         SZ_BYTE: w_misalign = 1'b0;
         SZ_HALF: w_misalign = i_addr[0];
         default: w_misalign = (i_addr[1:0] != 2'b00);
      endcase
   end

   load_extend u_load_extend (
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_raw    (i_ram_data_out),
      .o_data   (w_ext)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         IDLE: if (i_req) w_state_d = w_fault ? DONE : ACC1;
         ACC1: w_state_d = (r_size == SZ_DOUBLE) ? ACC2 : DONE;
         ACC2: w_state_d = DONE;
         DONE: w_state_d = IDLE;
      endcase
   end

   // Next values for the output flops; ACC1 is entered only from IDLE, so it uses live inputs.
   always_comb begin
      w_busy_d     = 1'b0;
      w_done_d     = 1'b0;
      w_fault_d    = 1'b0;
      w_ram_en_d   = 1'b0;
      w_ram_rw_d   = 1'b0;
      w_ram_addr_d = '0;
      w_ram_din_d  = '0;
      w_ram_size_d = SZ_BYTE;
      case (w_state_d)
         IDLE: ;
         ACC1: begin
            w_busy_d     = 1'b1;
            w_ram_en_d   = 1'b1;
            w_ram_rw_d   = ~i_load;
            w_ram_addr_d = i_addr;
            w_ram_din_d  = i_store_data;
            w_ram_size_d = (i_size == SZ_DOUBLE) ? SZ_WORD : i_size;
         end
         ACC2: begin
            w_busy_d     = 1'b1;
            w_ram_en_d   = 1'b1;
            w_ram_rw_d   = ~r_load;
            w_ram_addr_d = r_addr + 32'd4;
            w_ram_din_d  = r_store_data2;
            w_ram_size_d = SZ_WORD;
         end
         DONE: begin
            w_busy_d  = 1'b1;
            w_done_d  = 1'b1;
            w_fault_d = (r_state == IDLE);
         end
      endcase

      w_load_data_d  = r_load_data;
      w_load_data2_d = r_load_data2;
      if (r_state == ACC1 && r_load) w_load_data_d  = w_ext;
      if (r_state == ACC2 && r_load) w_load_data2_d = i_ram_data_out;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_load        <= 1'b0;
         r_signed      <= 1'b0;
         r_size        <= SZ_BYTE;
         r_addr        <= '0;
         r_store_data2 <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_fault       <= 1'b0;
         r_ram_en      <= 1'b0;
         r_ram_rw      <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_din     <= '0;
         r_ram_size    <= SZ_BYTE;
         r_load_data   <= '0;
         r_load_data2  <= '0;
      end else begin
         if (w_accept) begin
            r_load        <= i_load;
            r_signed      <= i_signed;
            r_size        <= i_size;
            r_addr        <= i_addr;
            r_store_data2 <= i_store_data2;
         end
         r_busy       <= w_busy_d;
         r_done       <= w_done_d;
         r_fault      <= w_fault_d;
         r_ram_en     <= w_ram_en_d;
         r_ram_rw     <= w_ram_rw_d;
         r_ram_addr   <= w_ram_addr_d;
         r_ram_din    <= w_ram_din_d;
         r_ram_size   <= w_ram_size_d;
         r_load_data  <= w_load_data_d;
         r_load_data2 <= w_load_data2_d;
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_fault       = r_fault;
   assign o_load_data   = r_load_data;
   assign o_load_data2  = r_load_data2;
   assign o_ram_enable  = r_ram_en;
   assign o_ram_rw      = r_ram_rw;
   assign o_ram_address = r_ram_addr;
   assign o_ram_data_in = r_ram_din;
   assign o_ram_size    = r_ram_size;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl with a behavioural 256x8 big-endian RAM and a completion scoreboard.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req = 1'b0, load = 1'b0, signd = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, sd = '0, sd2 = '0;
   logic        busy, done, fault, ram_en, ram_rw;
   logic [31:0] ld, ld2, ram_addr, ram_din, ram_dout;
   logic [1:0]  ram_size;

   logic [7:0]  mem [256] = '{default: 8'h00};

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        fault;
      logic [31:0] ld1;
      logic [31:0] ld2;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [34:0] acc_log[$];
   logic [31:0] m_ld1 = '0;
   logic [31:0] m_ld2 = '0;

   data_mem_ctrl #(.MEM_BYTES(256)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req          (req),
      .i_load         (load),
      .i_size         (size),
      .i_signed       (signd),
      .i_addr         (addr),
      .i_store_data   (sd),
      .i_store_data2  (sd2),
      .o_busy         (busy),
      .o_done         (done),
      .o_fault        (fault),
      .o_load_data    (ld),
      .o_load_data2   (ld2),
      .o_ram_enable   (ram_en),
      .o_ram_rw       (ram_rw),
      .o_ram_address  (ram_addr),
      .o_ram_data_in  (ram_din),
      .o_ram_size     (ram_size),
      .i_ram_data_out (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_en && ram_rw) begin
         case (ram_size)
            2'b00: mem[ram_addr[7:0]] <= ram_din[7:0];
            2'b01: begin
               mem[ram_addr[7:0]]        <= ram_din[15:8];
               mem[ram_addr[7:0] + 8'd1] <= ram_din[7:0];
            end
            default: begin
               mem[ram_addr[7:0]]        <= ram_din[31:24];
               mem[ram_addr[7:0] + 8'd1] <= ram_din[23:16];
               mem[ram_addr[7:0] + 8'd2] <= ram_din[15:8];
               mem[ram_addr[7:0] + 8'd3] <= ram_din[7:0];
            end
         endcase
      end
   end

   always_comb begin
      ram_dout = '0;
      case (ram_size)
         2'b00:   ram_dout = {24'h0, mem[ram_addr[7:0]]};
         2'b01:   ram_dout = {16'h0, mem[ram_addr[7:0]], mem[ram_addr[7:0] + 8'd1]};
         default: ram_dout = {mem[ram_addr[7:0]], mem[ram_addr[7:0] + 8'd1],
                              mem[ram_addr[7:0] + 8'd2], mem[ram_addr[7:0] + 8'd3]};
      endcase
   end

   // Completion monitor: every Done pops one expectation and checks timing, fault and data.
   always @(negedge clk) begin
      if (ram_en) acc_log.push_back({ram_rw, ram_size, ram_addr});
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: Done=1 at cycle %0d, required no completion", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (fault !== e.fault || cyc != e.due) begin
               errors++;
               $display("FAIL done_timing_fault: cycle %0d fault %b, required cycle %0d fault %b",
                        cyc, fault, e.due, e.fault);
            end
            checks++;
            if (ld !== e.ld1 || ld2 !== e.ld2) begin
               errors++;
               $display("FAIL load_data: got %h/%h, required %h/%h", ld, ld2, e.ld1, e.ld2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic l, input logic [1:0] s, input logic sg, input logic [31:0] a,
                        input logic [31:0] d1, input logic [31:0] d2, input logic f,
                        input logic [31:0] e1, input logic [31:0] e2, input int lat);
      exp_t e;
      @(negedge clk);
      load = l; size = s; signd = sg; addr = a; sd = d1; sd2 = d2; req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      if (l && !f) begin
         m_ld1 = e1;
         if (s == 2'b11) m_ld2 = e2;
      end
      e.fault = f; e.ld1 = m_ld1; e.ld2 = m_ld2; e.due = cyc + lat - 1;
      exp_q.push_back(e);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL completion_timeout: %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #12;
      checks++;
      if ({busy, done, fault, ram_en, ram_rw, ram_size} !== 6'b0 || ld !== 0 || ld2 !== 0 ||
          ram_addr !== 0 || ram_din !== 0) begin
         errors++;
         $display("FAIL reset_state: busy %b done %b fault %b en %b ld %h, required all 0",
                  busy, done, fault, ram_en, ld);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 32'h0, 2);
      checks++;
      if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL store_word_bytes: got %h%h%h%h, required deadbeef",
                  mem[16], mem[17], mem[18], mem[19]);
      end
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 2);
   endtask

   task automatic test_byte_half();
      issue(1'b0, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80, 32'h0, 1'b0, 32'h0, 32'h0, 2);
      checks++;
      if ({mem[32], mem[33], mem[34]} !== 24'h008000) begin
         errors++;
         $display("FAIL store_byte: got %h %h %h, required 00 80 00", mem[32], mem[33], mem[34]);
      end
      issue(1'b1, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0, 1'b0, 32'hFFFFFF80, 32'h0, 2);
      issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0, 1'b0, 32'h00000080, 32'h0, 2);
      issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h12348001, 32'h0, 1'b0, 32'h0, 32'h0, 2);
      checks++;
      if ({mem[34], mem[35]} !== 16'h8001) begin
         errors++;
         $display("FAIL store_half: got %h %h, required 80 01", mem[34], mem[35]);
      end
      issue(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0, 1'b0, 32'hFFFF8001, 32'h0, 2);
      issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0, 1'b0, 32'h00008001, 32'h0, 2);
   endtask

   task automatic test_double();
      acc_log.delete();
      issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h11111111, 32'h22222222, 1'b0, 32'h0, 32'h0, 3);
      checks++;
      if (acc_log.size() != 2 || acc_log[0] !== {1'b1, 2'b10, 32'h40} ||
          acc_log[1] !== {1'b1, 2'b10, 32'h44}) begin
         errors++;
         $display("FAIL double_store_seq: %0d accesses first %h, required 2 at 40 then 44 (rw=1)",
                  acc_log.size(), acc_log.size() > 0 ? acc_log[0] : 35'h0);
      end
      acc_log.delete();
      issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 32'h11111111, 32'h22222222, 3);
      checks++;
      if (acc_log.size() != 2 || acc_log[0] !== {1'b0, 2'b10, 32'h40} ||
          acc_log[1] !== {1'b0, 2'b10, 32'h44}) begin
         errors++;
         $display("FAIL double_load_seq: %0d accesses, required 2 at 40 then 44 (rw=0)",
                  acc_log.size());
      end
   endtask

   task automatic test_fault();
      acc_log.delete();
      issue(1'b0, 2'b01, 1'b0, 32'h03, 32'h0000BEEF, 32'h0, 1'b1, 32'h0, 32'h0, 1);
      issue(1'b1, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1);
      issue(1'b1, 2'b11, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1);
      issue(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1);
      checks++;
      if (acc_log.size() != 0 || {mem[3], mem[4]} !== 16'h0) begin
         errors++;
         $display("FAIL fault_no_access: %0d RAM accesses, mem[3..4]=%h%h, required 0 and 0000",
                  acc_log.size(), mem[3], mem[4]);
      end
      issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h01020304, 32'h0, 1'b0, 32'h0, 32'h0, 2);
      checks++;
      if ({mem[252], mem[253], mem[254], mem[255]} !== 32'h01020304) begin
         errors++;
         $display("FAIL store_top_word: got %h%h%h%h, required 01020304",
                  mem[252], mem[253], mem[254], mem[255]);
      end
      issue(1'b1, 2'b00, 1'b1, 32'hFF, 32'h0, 32'h0, 1'b0, 32'h00000004, 32'h0, 2);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   c;
      @(negedge clk);
      c = cyc;
      m_ld1 = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         e.fault = 1'b0; e.ld1 = m_ld1; e.ld2 = m_ld2; e.due = c + 2 + 3 * i;
         exp_q.push_back(e);
      end
      load = 1'b1; size = 2'b10; signd = 1'b0; addr = 32'h10; req = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== ((k % 3) != 0) || done !== ((k % 3) == 2)) begin
            errors++;
            $display("FAIL held_req_k%0d: busy %b done %b, required %b %b", k, busy, done,
                     (k % 3) != 0, (k % 3) == 2);
         end
      end
      req = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL held_req_done_count: %0d completions missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      load = 1'b0; size = 2'b11; signd = 1'b0; addr = 32'h80;
      sd = 32'hAAAAAAAA; sd2 = 32'h55555555; req = 1'b1;
      @(posedge clk);
      #2;
      req = 1'b0;
      checks++;
      if (ram_en !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 32'h80) begin
         errors++;
         $display("FAIL acc1_pins: en %b rw %b addr %h, required 1 1 00000080",
                  ram_en, ram_rw, ram_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, fault, ram_en, ram_rw, ram_size} !== 6'b0 || ld !== 0 || ld2 !== 0 ||
          ram_addr !== 0 || ram_din !== 0) begin
         errors++;
         $display("FAIL async_reset: busy %b en %b addr %h din %h ld %h, required all 0",
                  busy, ram_en, ram_addr, ram_din, ld);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_ld1 = '0;
      m_ld2 = '0;
      checks++;
      if ({mem[132], mem[133], mem[134], mem[135]} !== 32'h0) begin
         errors++;
         $display("FAIL aborted_second_word: got %h%h%h%h, required 00000000",
                  mem[132], mem[133], mem[134], mem[135]);
      end
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 2);
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_half();
      test_double();
      test_fault();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
